// File: rtl/key_buffer_if.sv
// key_buffer_if: CPU bus and interrupt signals between a bus master and the key buffer.
interface key_buffer_if;
  logic [63:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [63:0] bus_write_data;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done;
  modport master (
    output bus_address, bus_read_enable, bus_write_enable, bus_write_data, interrupt_done,
    input  bus_read_data, interrupt_vector
  );
  modport slave (
    input  bus_address, bus_read_enable, bus_write_enable, bus_write_data, interrupt_done,
    output bus_read_data, interrupt_vector
  );
endinterface

// File: rtl/key_buffer.sv
// key_buffer: PS/2 key-code FIFO with memory-mapped DATA/STATUS/CTRL registers and a key interrupt.
module key_buffer #(
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0010,
  parameter int          DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   ascii_code,
  input  logic         key_pressed,
  key_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, ien_q, ien_d, kp_q;
  logic [63:0]   rdata_q, rdata_d;
  state_t        state_q, state_d;
  logic          push, pop, do_push, empty, full, hit_data, hit_stat, hit_ctrl, wr_ctrl;
  logic          unused_wdata;
  assign unused_wdata = ^bus.bus_write_data[63:2];
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == CW'(DEPTH);
    hit_data = bus.bus_address == BASE;
    hit_stat = bus.bus_address == BASE + 64'h8;
    hit_ctrl = bus.bus_address == BASE + 64'h10;
    push     = key_pressed & ~kp_q;
    pop      = bus.bus_read_enable & hit_data & ~empty;
    do_push  = push & (~full | pop);
    wr_ctrl  = bus.bus_write_enable & hit_ctrl;
    head_d   = pop ? head_q + 1'b1 : head_q;
    tail_d   = do_push ? tail_q + 1'b1 : tail_q;
    count_d  = count_q + CW'(do_push) - CW'(pop);
    ovf_d    = (ovf_q & ~(wr_ctrl & bus.bus_write_data[1])) | (push & full & ~pop);
    ien_d    = wr_ctrl ? bus.bus_write_data[0] : ien_q;
    rdata_d  = !bus.bus_read_enable ? rdata_q :
               hit_data ? {56'b0, empty ? 8'h00 : mem_q[head_q]} :
               hit_stat ? {48'b0, 8'(count_q), 5'b0, ovf_q, full, empty} :
               hit_ctrl ? {63'b0, ien_q} : '0;
    // A key landing in the same cycle the FIFO is seen drained re-raises the interrupt directly.
    state_d  = !ien_q ? IDLE :
               state_q == IDLE ? (empty ? IDLE : PEND) :
               state_q == PEND ? (bus.interrupt_done ? ACK : PEND) :
               empty ? (push ? PEND : IDLE) : ACK;
  end
  assign bus.interrupt_vector = state_q == PEND ? 4'd1 : 4'd0;
  assign bus.bus_read_data    = rdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ien_q   <= 1'b1;
      kp_q    <= 1'b1;
      rdata_q <= '0;
      state_q <= IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ien_q   <= ien_d;
      kp_q    <= key_pressed;
      rdata_q <= rdata_d;
      state_q <= state_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= ascii_code;
  end
endmodule

// File: tb/tb_key_buffer.sv
// tb_key_buffer: directed table, corner sequences and randomized run against a queue-based model.
module tb_key_buffer;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0010;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset, key_pressed;
  logic [7:0] ascii_code;
  key_buffer_if bus();
  key_buffer #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ascii_code(ascii_code), .key_pressed(key_pressed), .bus(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [7:0]  mq[$];
  bit          m_ovf, m_ien, m_kpd;
  int          m_st;
  logic [63:0] m_rd;
  typedef struct {
    bit r, kp; logic [7:0] code; bit re, we;
    logic [63:0] off, wd, e_rd; logic [3:0] e_iv;
  } vec_t;
  vec_t tbl[20];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit push, pop, hd, hs, hc, wc, emp;
    if (reset) begin
      mq.delete(); m_ovf = 0; m_ien = 1; m_st = 0; m_rd = '0; m_kpd = 1;
      return;
    end
    push = key_pressed && !m_kpd;
    m_kpd = key_pressed;
    hd = bus.bus_address == BASE;
    hs = bus.bus_address == BASE + 64'h8;
    hc = bus.bus_address == BASE + 64'h10;
    emp = mq.size() == 0;
    if (bus.bus_read_enable)
      m_rd = hd ? (emp ? 64'h0 : 64'(mq[0])) :
             hs ? {48'b0, 8'(mq.size()), 5'b0, m_ovf, mq.size() == DEPTH, emp} :
             hc ? 64'(m_ien) : 64'h0;
    if (!m_ien) m_st = 0;
    else if (m_st == 0) m_st = emp ? 0 : 1;
    else if (m_st == 1) m_st = bus.interrupt_done ? 2 : 1;
    else if (emp) m_st = push ? 1 : 0;
    pop = bus.bus_read_enable && hd && !emp;
    if (pop) void'(mq.pop_front());
    wc = bus.bus_write_enable && hc;
    if (wc && bus.bus_write_data[1]) m_ovf = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(ascii_code);
      else m_ovf = 1;
    end
    if (wc) m_ien = bus.bus_write_data[0];
  endtask

  task automatic cyc(bit r, bit kp, logic [7:0] code, bit re, bit we,
                     logic [63:0] off, logic [63:0] wd, bit done);
    reset = r; key_pressed = kp; ascii_code = code;
    bus.bus_read_enable = re; bus.bus_write_enable = we;
    bus.bus_address = BASE + off; bus.bus_write_data = wd; bus.interrupt_done = done;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();                     cyc(0, 0, 8'h0, 0, 0, 0, 0, 0); endtask
  task automatic rst();                     cyc(1, 0, 8'h0, 0, 0, 0, 0, 0); endtask
  task automatic rd(logic [63:0] off);      cyc(0, 0, 8'h0, 1, 0, off, 0, 0); endtask
  task automatic wr(logic [63:0] off, logic [63:0] wd); cyc(0, 0, 8'h0, 0, 1, off, wd, 0); endtask
  task automatic press(logic [7:0] c);
    cyc(0, 1, c, 0, 0, 0, 0, 0);
    nop();
  endtask

  initial begin
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[1]  = '{0, 0, 8'h00, 0, 1, 64'h10, 64'h0,  64'h000, 4'd0};
    tbl[2]  = '{0, 1, 8'h41, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[3]  = '{0, 0, 8'h00, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[4]  = '{0, 1, 8'h42, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[5]  = '{0, 0, 8'h00, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[6]  = '{0, 1, 8'h43, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[7]  = '{0, 0, 8'h00, 0, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[8]  = '{0, 0, 8'h00, 1, 0, 64'h08, 64'h0,  64'h300, 4'd0};
    tbl[9]  = '{0, 0, 8'h00, 1, 0, 64'h00, 64'h0,  64'h041, 4'd0};
    tbl[10] = '{0, 0, 8'h00, 1, 0, 64'h00, 64'h0,  64'h042, 4'd0};
    tbl[11] = '{0, 0, 8'h00, 1, 0, 64'h00, 64'h0,  64'h043, 4'd0};
    tbl[12] = '{0, 0, 8'h00, 1, 0, 64'h00, 64'h0,  64'h000, 4'd0};
    tbl[13] = '{0, 0, 8'h00, 1, 0, 64'h08, 64'h0,  64'h001, 4'd0};
    tbl[14] = '{0, 0, 8'h00, 1, 0, 64'h10, 64'h0,  64'h000, 4'd0};
    tbl[15] = '{0, 0, 8'h00, 0, 1, 64'h10, 64'h1,  64'h000, 4'd0};
    tbl[16] = '{0, 0, 8'h00, 1, 0, 64'h10, 64'h0,  64'h001, 4'd0};
    tbl[17] = '{0, 0, 8'h00, 1, 0, 64'h18, 64'h0,  64'h000, 4'd0};
    tbl[18] = '{0, 0, 8'h00, 0, 1, 64'h00, 64'hff, 64'h000, 4'd0};
    tbl[19] = '{0, 0, 8'h00, 1, 0, 64'h08, 64'h0,  64'h001, 4'd0};
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].r, tbl[i].kp, tbl[i].code, tbl[i].re, tbl[i].we, tbl[i].off, tbl[i].wd, 0);
      check($sformatf("tbl%0d rd", i), bus.bus_read_data, tbl[i].e_rd);
      check($sformatf("tbl%0d iv", i), 64'(bus.interrupt_vector), 64'(tbl[i].e_iv));
    end
    // nine pushes into an eight-deep FIFO
    rst(); wr('h10, 0);
    for (int i = 0; i < 9; i++) press(8'h50 + 8'(i));
    rd('h8); check("ovf status", bus.bus_read_data, 64'h806);
    for (int i = 0; i < 8; i++) begin
      rd('h0); check($sformatf("ovf pop%0d", i), bus.bus_read_data, 64'h50 + 64'(i));
    end
    wr('h10, 2); rd('h8); check("ovf cleared", bus.bus_read_data, 64'h001);
    // push and pop together while full
    rst(); wr('h10, 0);
    for (int i = 0; i < 8; i++) press(8'h60 + 8'(i));
    cyc(0, 1, 8'h70, 1, 0, 'h0, 0, 0); check("full pushpop rd", bus.bus_read_data, 64'h60);
    cyc(0, 0, 8'h00, 1, 0, 'h8, 0, 0); check("full pushpop status", bus.bus_read_data, 64'h802);
    for (int i = 1; i < 8; i++) begin
      rd('h0); check($sformatf("full drain%0d", i), bus.bus_read_data, 64'h60 + 64'(i));
    end
    rd('h0); check("full drain last", bus.bus_read_data, 64'h70);
    // interrupt handshake
    rst(); nop(); press(8'h41);
    check("irq raised", 64'(bus.interrupt_vector), 64'd1);
    cyc(0, 0, 8'h00, 0, 0, 0, 0, 1); check("irq acked", 64'(bus.interrupt_vector), 64'd0);
    rd('h0); check("irq data", bus.bus_read_data, 64'h41);
    nop(); nop(); press(8'h42);
    check("irq again", 64'(bus.interrupt_vector), 64'd1);
    // key held through reset release, then reset with keys buffered
    cyc(1, 1, 8'h55, 0, 0, 0, 0, 0); cyc(1, 1, 8'h55, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h55, 0, 0, 0, 0, 0);
    nop(); rd('h8); check("held no push", bus.bus_read_data, 64'h001);
    check("held no irq", 64'(bus.interrupt_vector), 64'd0);
    press(8'h31); press(8'h32); press(8'h33);
    rd('h8); check("three buffered", bus.bus_read_data, 64'h300);
    rst(); rd('h8); check("reset flushes", bus.bus_read_data, 64'h001);
    check("reset irq", 64'(bus.interrupt_vector), 64'd0);
    // randomized run against the model
    rst();
    for (int n = 0; n < 4000; n++) begin
      int sel;
      logic [63:0] off, wd;
      sel = $urandom_range(0, 7);
      off = sel < 4 ? 64'h0 : sel == 4 ? 64'h8 : sel == 5 ? 64'h10 : sel == 6 ? 64'h18 : {$urandom, $urandom};
      wd = {$urandom, $urandom};
      wd[0] = $urandom_range(0, 3) != 0;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 4, 8'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, off, wd, $urandom_range(0, 5) == 0);
      check("rnd rd", bus.bus_read_data, m_rd);
      check("rnd iv", 64'(bus.interrupt_vector), m_st == 1 ? 64'd1 : 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_buffer.md
KEY_BUFFER -- requirements
Module: key_buffer

Interface
REQ-001 Parameter BASE, default 64'h0000_0000_8000_0010: bus base address of the block.
REQ-002 Parameter DEPTH, default 8: FIFO depth in entries, a power of two from 2 to 64.
REQ-003 clk  input  1: single clock for all state.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 ascii_code  input  8: key code from the PS/2 decoder, valid while key_pressed is high.
REQ-006 key_pressed  input  1: level from the PS/2 decoder, already in the clk domain.
REQ-007 bus_address  input  64: CPU bus address.
REQ-008 bus_read_enable  input  1: single-cycle read strobe.
REQ-009 bus_write_enable  input  1: single-cycle write strobe.
REQ-010 bus_write_data  input  64: write data.
REQ-011 bus_read_data  output  64: registered read data.
REQ-012 interrupt_vector  output  4: 4'd1 while a key interrupt is pending, else 4'd0.
REQ-013 interrupt_done  input  1: CPU acknowledge pulse.

Function
REQ-014 Push event: rising edge of key_pressed, detected through a 1-cycle delay register (key_pressed high now, delayed value low); the push writes ascii_code into the FIFO.
REQ-015 Register map (byte offsets from BASE):
- +0x0 DATA (RO): read returns {56'b0, head entry} and pops; on empty, returns 0 with no pop.
- +0x8 STATUS (RO): {48'b0, count[7:0], 5'b0, overflow, full, empty}.
- +0x10 CTRL (RW): bit0 = irq_enable, bit1 = write-1-to-clear overflow (reads back 0); other bits read 0.
REQ-016 Address decode is an exact 64-bit compare; unmapped offsets read 0 and ignore writes.
REQ-017 bus_read_data is registered: valid the cycle after bus_read_enable; it holds the last value otherwise.
REQ-018 STATUS reads sample state before any push in the same cycle.
REQ-019 FIFO storage uses head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-020 Push with FIFO full and no pop in the same cycle: data is dropped, sticky overflow bit is set, pointers are unchanged.
REQ-021 Push and pop in the same cycle, FIFO non-empty (including full): both occur, count is unchanged, overflow is not set.
REQ-022 Push and pop in the same cycle, FIFO empty: push occurs, pop is ignored, read returns 0.
REQ-023 Interrupt FSM states:
- IDLE to PEND when irq_enable=1 and FIFO non-empty.
- PEND to ACK on interrupt_done.
- ACK to IDLE once FIFO is empty.
- ACK to PEND when more keys arrive after the FIFO has drained.
REQ-024 interrupt_vector = 4'd1 only in PEND.
REQ-025 Clearing irq_enable in PEND or ACK returns the FSM to IDLE next cycle.
REQ-026 interrupt_done in IDLE is ignored.

Reset
REQ-027 On reset, the following take these values:
- FIFO empty, head=tail=0, count=0.
- overflow=0, irq_enable=1.
- FSM=IDLE, interrupt_vector=0, bus_read_data=0.
- Delay register = 1, so a key held through reset release produces no push.
REQ-028 Reset asserted mid-operation discards all buffered keys and takes effect on the next clk edge.
REQ-029 FIFO contents are not reset; they are unobservable while empty.

Verification
REQ-030 Three pulses on key_pressed with codes 0x41, 0x42, 0x43, then three DATA reads -> read data 0x41, 0x42, 0x43, each one cycle after its strobe; a fourth read -> 0, STATUS empty=1.
REQ-031 Nine pushes with DEPTH=8 -> STATUS = count 8, full=1, overflow=1; eight reads return the first eight codes; CTRL write 0x2 -> overflow=0.
REQ-032 FIFO full, push and DATA read in the same cycle -> count stays 8, overflow=0, oldest entry returned.
REQ-033 Push 0x41 -> interrupt_vector=1 within 2 cycles; interrupt_done pulse -> 0; DATA read empties the FIFO, then push 0x42 -> interrupt_vector=1 again.
REQ-034 key_pressed held high across reset release -> no push; reset asserted with 3 entries buffered -> STATUS empty=1, interrupt_vector=0.
